// File: rtl/codec_config_sequencer.sv
// Audio codec bring-up sequencer: walks a fixed register table and issues one
// 24-bit I2C write per entry, with per-entry retry on NACK or timeout.
module codec_config_sequencer #(
  parameter int          NUM_REGS      = 11,
  parameter logic [7:0]  DEV_ADDR      = 8'h34,
  parameter int          POWERUP_DELAY = 1024,
  parameter int          INTER_GAP     = 64,
  parameter int          MAX_RETRIES   = 3,
  parameter int          TIMEOUT       = 8192
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_go,
  output logic        i2c_start,
  output logic [23:0] i2c_data,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [3:0]  error_index
);

  localparam int CNT_MAX = (POWERUP_DELAY > INTER_GAP)
                         ? ((POWERUP_DELAY > TIMEOUT) ? POWERUP_DELAY : TIMEOUT)
                         : ((INTER_GAP > TIMEOUT) ? INTER_GAP : TIMEOUT);
  localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CW-1:0] PD_LAST  = CW'(POWERUP_DELAY - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(INTER_GAP - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MX = RW'(MAX_RETRIES);
  localparam logic [3:0]    IDX_LAST = 4'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_POWERUP, S_LOAD, S_ISSUE, S_SETTLE, S_WAIT, S_CHECK, S_GAP, S_DONE, S_ERROR
  } state_e;

  // Table entry = {reg[6:0], val[8:0]}
  function automatic logic [15:0] tbl(input logic [3:0] i);
    case (i)
      4'd0:    tbl = 16'h1E00;
      4'd1:    tbl = 16'h0017;
      4'd2:    tbl = 16'h0217;
      4'd3:    tbl = 16'h0479;
      4'd4:    tbl = 16'h0679;
      4'd5:    tbl = 16'h0812;
      4'd6:    tbl = 16'h0A00;
      4'd7:    tbl = 16'h0C00;
      4'd8:    tbl = 16'h0E42;
      4'd9:    tbl = 16'h1000;
      4'd10:   tbl = 16'h1201;
      default: tbl = 16'h0000;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   data_q, data_d;
  logic          ok_q, ok_d;
  logic [3:0]    eidx_q, eidx_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_POWERUP;
      idx_q   <= '0;
      retry_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      ok_q    <= 1'b0;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      ok_q    <= ok_d;
      eidx_q  <= eidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ok_d    = ok_q;
    eidx_d  = eidx_q;
    case (state_q)
      S_POWERUP: begin
        if (cnt_q == PD_LAST) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOAD: begin
        data_d  = {DEV_ADDR, tbl(idx_q)};
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      // done may still be high from the previous word; don't look at it yet
      S_SETTLE: state_d = S_WAIT;
      S_WAIT: begin
        if (i2c_done) begin
          ok_d    = i2c_ack;
          state_d = S_CHECK;
        end else if (cnt_q == TO_LAST) begin
          ok_d    = 1'b0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (ok_q) begin
          retry_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_GAP;
          end
        end else if (retry_q < RETRY_MX) begin
          retry_d = retry_q + RW'(1);
          state_d = S_GAP;
        end else begin
          eidx_d  = idx_q;
          state_d = S_ERROR;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE, S_ERROR: begin
        if (cfg_go) begin
          idx_d   = '0;
          retry_d = '0;
          eidx_d  = '0;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_POWERUP;
    endcase
  end

  assign i2c_start   = (state_q == S_ISSUE);
  assign i2c_data    = data_q;
  assign busy        = !((state_q == S_DONE) || (state_q == S_ERROR));
  assign cfg_done    = (state_q == S_DONE);
  assign cfg_error   = (state_q == S_ERROR);
  assign error_index = eidx_q;

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: behavioural I2C controller responder plus
// an expected-write-sequence model derived from per-entry NACK counts.
module tb_codec_config_sequencer;
  localparam int NR = 11, PD = 32, G = 8, MR = 3, TO = 64;

  logic        clk = 1'b0, reset_n = 1'b0, cfg_go = 1'b0;
  logic        i2c_done = 1'b1, i2c_ack = 1'b1;
  logic        i2c_start, busy, cfg_done, cfg_error;
  logic [23:0] i2c_data;
  logic [3:0]  error_index;

  int checks = 0, errors = 0, cyc = 0;
  logic [15:0] tbl [16];
  logic [23:0] obs_q[$];
  int          obs_t[$];
  logic [23:0] exp_q[$];
  bit          exp_err;
  int          exp_eidx;
  int          nack_cfg [16];
  int          nack_used[16];
  int          lat_min = 4, lat_max = 4, stale_lag = 0, overlap = 0;
  bit          never_done = 1'b0, m_busy = 1'b0, m_ok = 1'b1;
  int          m_cnt = 0, m_lag = 0;

  codec_config_sequencer #(
    .NUM_REGS(NR), .DEV_ADDR(8'h34), .POWERUP_DELAY(PD),
    .INTER_GAP(G), .MAX_RETRIES(MR), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_go(cfg_go),
    .i2c_start(i2c_start), .i2c_data(i2c_data),
    .i2c_done(i2c_done), .i2c_ack(i2c_ack),
    .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error),
    .error_index(error_index)
  );

  always #5 clk = ~clk;

  task automatic count_cycles();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  // Controller responder, acting on negedges so it never races the DUT edge.
  task automatic ctrl_model();
    forever begin
      @(negedge clk);
      if (i2c_start) begin
        int e;
        e = 0;
        for (int i = 0; i < NR; i++) if ({8'h34, tbl[i]} == i2c_data) e = i;
        obs_q.push_back(i2c_data);
        obs_t.push_back(cyc);
        if (m_busy) overlap++;
        m_ok = (nack_used[e] >= nack_cfg[e]);
        if (!m_ok) nack_used[e]++;
        m_busy = !never_done;
        m_cnt  = int'($urandom_range(lat_max, lat_min));
        m_lag  = stale_lag;
        if (m_lag == 0) i2c_done = 1'b0;
      end else if (m_busy) begin
        if (m_lag > 0) begin
          m_lag--;
          if (m_lag == 0) i2c_done = 1'b0;
        end else begin
          m_cnt--;
          if (m_cnt <= 0) begin
            i2c_done = 1'b1;
            i2c_ack  = m_ok;
            m_busy   = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic model_cfg(input int lmin, input int lmax, input int lag, input bit nd);
    lat_min = lmin; lat_max = lmax; stale_lag = lag; never_done = nd;
    for (int i = 0; i < 16; i++) begin nack_cfg[i] = 0; nack_used[i] = 0; end
    m_busy = 1'b0; overlap = 0;
    i2c_done = !nd; i2c_ack = 1'b1;
    obs_q.delete(); obs_t.delete();
  endtask

  task automatic hold_reset();
    @(negedge clk);
    reset_n = 1'b0;
    cfg_go  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_run(output int base);
    @(negedge clk);
    reset_n = 1'b1;
    base    = cyc;
  endtask

  task automatic wait_idle(input int budget, output bit expired);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin @(negedge clk); n++; end
    expired = busy;
  endtask

  task automatic pulse_go();
    @(negedge clk);
    cfg_go = 1'b1;
    @(negedge clk);
    cfg_go = 1'b0;
  endtask

  // Expected writes: each entry is retried once per NACK until it ACKs, or
  // the run stops at the first entry needing more than MR retries.
  task automatic build_exp();
    exp_q.delete(); exp_err = 1'b0; exp_eidx = 0;
    for (int e = 0; e < NR; e++) begin
      int n;
      n = (nack_cfg[e] > MR) ? MR + 1 : nack_cfg[e] + 1;
      for (int k = 0; k < n; k++) exp_q.push_back({8'h34, tbl[e]});
      if (nack_cfg[e] > MR) begin
        exp_err = 1'b1; exp_eidx = e;
        return;
      end
    end
  endtask

  function automatic int seq_diff();
    if (obs_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    bit [8:0] got;
    model_cfg(4, 4, 0, 1'b0);
    hold_reset();
    #1;
    got = {i2c_start, busy, cfg_done, cfg_error, error_index, 1'b0};
    checks++;
    if (got !== 9'b0_1_0_0_0000_0) begin
      errors++; $display("FAIL reset_flags: got %b required 010000000", got);
    end
    checks++;
    if (i2c_data !== 24'h0) begin
      errors++; $display("FAIL reset_data: got %h required 000000", i2c_data);
    end
  endtask

  task automatic test_ack_all();
    int base, d; bit to;
    model_cfg(12, 12, 0, 1'b0);
    build_exp();
    start_run(base);
    wait_idle(3000, to);
    checks++;
    if (to) begin errors++; $display("FAIL ack_all_timeout: busy %b required 0", busy); end
    checks++;
    if (obs_t.size() == 0 || obs_t[0] - base + 1 != PD + 2) begin
      errors++; $display("FAIL ack_all_first_start: edge %0d required %0d",
                         (obs_t.size() > 0) ? obs_t[0] - base + 1 : -1, PD + 2);
    end
    d = seq_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL ack_all_seq: diff at %0d (n=%0d) required match", d, obs_q.size()); end
    checks++;
    if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== 24'h341201) begin
      errors++; $display("FAIL ack_all_last: got %h required 341201",
                         (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 24'hx);
    end
    for (int i = 1; i < obs_t.size(); i++) begin
      checks++;
      if (obs_t[i] - obs_t[i-1] != 12 + G + 3) begin
        errors++; $display("FAIL ack_all_spacing[%0d]: got %0d required %0d", i, obs_t[i] - obs_t[i-1], 12 + G + 3);
      end
    end
    checks++;
    if ({cfg_done, busy, cfg_error, overlap != 0} !== 4'b1000) begin
      errors++; $display("FAIL ack_all_status: done/busy/err/ovl %b%b%b%b required 1000", cfg_done, busy, cfg_error, overlap != 0);
    end
  endtask

  task automatic test_nack_retry();
    int base, d, n, first; bit to;
    model_cfg(10, 10, 0, 1'b0);
    nack_cfg[3] = 2;
    build_exp();
    start_run(base);
    wait_idle(3000, to);
    d = seq_diff();
    checks++;
    if (to || d != -1) begin errors++; $display("FAIL nack_retry_seq: diff %0d timeout %b required match", d, to); end
    n = 0; first = -1;
    foreach (obs_q[i]) if (obs_q[i] === 24'h340479) begin n++; if (first < 0) first = i; end
    checks++;
    if (n != 3) begin errors++; $display("FAIL nack_retry_count: got %0d required 3", n); end
    if (first > 0 && first + 2 < obs_t.size()) begin
      for (int i = first + 1; i <= first + 2; i++) begin
        checks++;
        if (obs_t[i] - obs_t[i-1] != 10 + G + 3) begin
          errors++; $display("FAIL nack_retry_gap: got %0d required %0d", obs_t[i] - obs_t[i-1], 10 + G + 3);
        end
      end
    end
    checks++;
    if ({cfg_done, cfg_error} !== 2'b10) begin
      errors++; $display("FAIL nack_retry_status: done/err %b%b required 10", cfg_done, cfg_error);
    end
  endtask

  task automatic test_nack_error();
    int base, n, sz; bit to;
    model_cfg(6, 14, 0, 1'b0);
    nack_cfg[5] = 99;
    build_exp();
    start_run(base);
    wait_idle(3000, to);
    n = 0;
    foreach (obs_q[i]) if (obs_q[i] === 24'h340812) n++;
    checks++;
    if (to || n != 4) begin errors++; $display("FAIL nack_err_count: got %0d timeout %b required 4", n, to); end
    checks++;
    if ({cfg_error, cfg_done, busy} !== 3'b100 || error_index !== 4'd5) begin
      errors++; $display("FAIL nack_err_status: err/done/busy %b%b%b idx %0d required 100 idx 5", cfg_error, cfg_done, busy, error_index);
    end
    sz = obs_q.size();
    repeat (200) @(negedge clk);
    checks++;
    if (obs_q.size() != sz || seq_diff() != -1) begin
      errors++; $display("FAIL nack_err_quiet: starts %0d required %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_stale_done();
    int base, d; bit to;
    model_cfg(6, 6, 2, 1'b0);
    build_exp();
    start_run(base);
    wait_idle(3000, to);
    d = seq_diff();
    checks++;
    if (to || d != -1 || overlap != 0) begin
      errors++; $display("FAIL stale_done: diff %0d overlap %0d timeout %b required -1 0 0", d, overlap, to);
    end
    for (int i = 1; i < obs_t.size(); i++) begin
      checks++;
      if (obs_t[i] - obs_t[i-1] != 2 + 6 + G + 3) begin
        errors++; $display("FAIL stale_spacing[%0d]: got %0d required %0d", i, obs_t[i] - obs_t[i-1], 2 + 6 + G + 3);
      end
    end
  endtask

  task automatic test_timeout();
    int base; bit to;
    model_cfg(4, 4, 0, 1'b1);
    start_run(base);
    wait_idle(3000, to);
    checks++;
    if (to || obs_q.size() != 4) begin errors++; $display("FAIL timeout_attempts: got %0d required 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== 24'h341E00 || (i > 0 && obs_t[i] - obs_t[i-1] != TO + G + 4)) begin
        errors++; $display("FAIL timeout_attempt[%0d]: word %h spacing %0d required 341E00 %0d",
                           i, obs_q[i], (i > 0) ? obs_t[i] - obs_t[i-1] : 0, TO + G + 4);
      end
    end
    checks++;
    if (cfg_error !== 1'b1 || error_index !== 4'd0) begin
      errors++; $display("FAIL timeout_status: err %b idx %0d required 1 0", cfg_error, error_index);
    end
    i2c_done = 1'b1;
  endtask

  task automatic test_restart();
    int base, gc, n, d; bit to;
    model_cfg(5, 9, 0, 1'b0);
    build_exp();
    start_run(base);
    wait_idle(3000, to);
    obs_q.delete(); obs_t.delete();
    @(negedge clk);
    cfg_go = 1'b1; gc = cyc;
    @(negedge clk);
    cfg_go = 1'b0;
    n = 0;
    while (obs_q.size() == 0 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (obs_q.size() == 0 || obs_t[0] - gc != 2 || obs_q[0] !== 24'h341E00) begin
      errors++; $display("FAIL restart_first: delay %0d word %h required 2 341E00",
                         (obs_t.size() > 0) ? obs_t[0] - gc : -1, (obs_q.size() > 0) ? obs_q[0] : 24'hx);
    end
    wait_idle(3000, to);
    d = seq_diff();
    checks++;
    if (to || d != -1 || cfg_done !== 1'b1) begin
      errors++; $display("FAIL restart_seq: diff %0d done %b required -1 1", d, cfg_done);
    end
  endtask

  task automatic test_go_busy();
    int base, n, d; bit to;
    model_cfg(8, 8, 0, 1'b0);
    build_exp();
    start_run(base);
    repeat (10) @(negedge clk);
    pulse_go();
    n = 0;
    while (obs_q.size() < 3 && n < 1000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    pulse_go();
    wait_idle(3000, to);
    d = seq_diff();
    checks++;
    if (to || d != -1) begin errors++; $display("FAIL go_busy_seq: diff %0d required -1", d); end
    checks++;
    if (obs_t.size() == 0 || obs_t[0] - base + 1 != PD + 2) begin
      errors++; $display("FAIL go_busy_first: edge %0d required %0d", (obs_t.size() > 0) ? obs_t[0] - base + 1 : -1, PD + 2);
    end
  endtask

  task automatic test_reset_mid();
    int base, n, d; bit to; bit [8:0] got;
    model_cfg(15, 15, 0, 1'b0);
    build_exp();
    start_run(base);
    n = 0;
    while (obs_q.size() < 8 && n < 2000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != 8 || obs_q[7] !== 24'h340C00) begin
      errors++; $display("FAIL reset_mid_reach: starts %0d required 8 ending 340C00", obs_q.size());
    end
    #2 reset_n = 1'b0;
    #1;
    got = {i2c_start, busy, cfg_done, cfg_error, error_index, 1'b0};
    checks++;
    if (got !== 9'b0_1_0_0_0000_0 || i2c_data !== 24'h0) begin
      errors++; $display("FAIL reset_mid_outputs: flags %b data %h required 010000000 000000", got, i2c_data);
    end
    repeat (2) @(negedge clk);
    obs_q.delete(); obs_t.delete();
    start_run(base);
    wait_idle(3000, to);
    d = seq_diff();
    checks++;
    if (to || d != -1 || overlap != 0) begin
      errors++; $display("FAIL reset_mid_seq: diff %0d overlap %0d required -1 0", d, overlap);
    end
    checks++;
    if (obs_t.size() == 0 || obs_t[0] - base + 1 != PD + 2) begin
      errors++; $display("FAIL reset_mid_powerup: edge %0d required %0d", (obs_t.size() > 0) ? obs_t[0] - base + 1 : -1, PD + 2);
    end
  endtask

  task automatic test_random();
    int base, d; bit to;
    for (int it = 0; it < 4; it++) begin
      hold_reset();
      model_cfg(3, 20, 0, 1'b0);
      for (int e = 0; e < NR; e++)
        nack_cfg[e] = ($urandom_range(9, 0) < 7) ? 0 : int'($urandom_range(4, 1));
      build_exp();
      start_run(base);
      wait_idle(5000, to);
      d = seq_diff();
      checks++;
      if (to || d != -1 || overlap != 0) begin
        errors++; $display("FAIL random[%0d]_seq: diff %0d overlap %0d required -1 0", it, d, overlap);
      end
      checks++;
      if ({cfg_done, cfg_error} !== {!exp_err, exp_err} || error_index !== (exp_err ? 4'(exp_eidx) : 4'd0)) begin
        errors++; $display("FAIL random[%0d]_status: done/err %b%b idx %0d required %b%b idx %0d",
                           it, cfg_done, cfg_error, error_index, !exp_err, exp_err, exp_err ? exp_eidx : 0);
      end
    end
  endtask

  initial begin
    tbl = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679, 16'h0812,
            16'h0A00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201,
            16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    fork
      count_cycles();
      ctrl_model();
    join_none
    test_reset();
    test_ack_all();
    hold_reset(); test_nack_retry();
    hold_reset(); test_nack_error();
    hold_reset(); test_stale_done();
    hold_reset(); test_timeout();
    hold_reset(); test_restart();
    hold_reset(); test_go_busy();
    hold_reset(); test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
